fpu_issue_ctrl: RTL and testbench

- Issue/collect stage that sits directly upstream of FPU_32b and consumes its outputs.
- Accepts add/sub requests on a valid/ready interface and holds the operands stable on the FPU_32b input ports for a fixed latency.
- Captures the result and the five exception flags, then presents them on a valid/ready response interface.
- Allows one operation in flight, matching the non-pipelined FPU_32b.

---
 rtl/fpu_pkg.sv | 26 ++
 rtl/fpu_issue_ctrl.sv | 148 ++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU_32b issue/collect logic: opcode and
// rounding-mode encodings, exception flag bit positions and the issue FSM
// state type.
package fpu_pkg;

    localparam logic FPU_OP_ADD = 1'b0;
    localparam logic FPU_OP_SUB = 1'b1;

    localparam logic [1:0] RM_NEAREST = 2'b00;
    localparam logic [1:0] RM_ZERO    = 2'b01;
    localparam logic [1:0] RM_UP      = 2'b10;
    localparam logic [1:0] RM_DOWN    = 2'b11;

    localparam int FLG_INE  = 4;
    localparam int FLG_OVF  = 3;
    localparam int FLG_UNF  = 2;
    localparam int FLG_INF  = 1;
    localparam int FLG_ZERO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } issue_state_t;

endpackage

// File: rtl/fpu_issue_ctrl.sv
// Issue/collect stage in front of a non-pipelined FPU_32b.
// A request is latched onto the fpu_* ports, a down-counter waits FPU_LAT
// edges, then the FPU result and flags are captured and offered on the
// response handshake. One operation in flight at a time.
// Optional macro FPU_ISSUE_STATS_EN adds handshake/exception counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request; fpu_* hold the last issued operands
// ST_WAIT | operands held on fpu_*, counting down to result capture
// ST_DONE | captured result offered on rsp_*, waiting for rsp_ready_i
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int FPU_LAT = 5,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        RST,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_opa_i,
    input  logic [31:0] req_opb_i,
    input  logic        req_op_i,
    input  logic [1:0]  req_mode_i,
    output logic [31:0] fpu_opa_o,
    output logic [31:0] fpu_opb_o,
    output logic        fpu_op_o,
    output logic [1:0]  fpu_mode_o,
    input  logic [31:0] fpu_result_i,
    input  logic [4:0]  fpu_flags_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic [4:0]  rsp_flags_o,
    output logic        busy_o
`ifdef FPU_ISSUE_STATS_EN
    ,
    output logic [31:0] stat_ops_o,
    output logic [31:0] stat_exc_o,
    input  logic        stat_clr_i
`endif
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(FPU_LAT - 1);

    issue_state_t     r_state;
    issue_state_t     w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_capture;

    // State register
    always_ff @(posedge clk_i) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and the accept/capture strobes
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand latch, latency down-counter and result capture
    always_ff @(posedge clk_i) begin
        if (RST) begin
            r_cnt        <= '0;
            fpu_opa_o    <= '0;
            fpu_opb_o    <= '0;
            fpu_op_o     <= 1'b0;
            fpu_mode_o   <= '0;
            rsp_result_o <= '0;
            rsp_flags_o  <= '0;
        end else begin
            if (w_accept) begin
                fpu_opa_o  <= req_opa_i;
                fpu_opb_o  <= req_opb_i;
                fpu_op_o   <= req_op_i;
                fpu_mode_o <= req_mode_i;
                r_cnt      <= LAT_M1;
            end else if ((r_state == ST_WAIT) && !w_capture) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                rsp_result_o <= fpu_result_i;
                rsp_flags_o  <= fpu_flags_i;
            end
        end
    end

    assign req_ready_o = (r_state == ST_IDLE);
    assign rsp_valid_o = (r_state == ST_DONE);
    assign busy_o      = (r_state != ST_IDLE);

`ifdef FPU_ISSUE_STATS_EN
    logic        w_handshake;
    logic        w_exc;
    logic [31:0] r_stat_ops;
    logic [31:0] r_stat_exc;

    assign w_handshake = (r_state == ST_DONE) && rsp_ready_i;
    assign w_exc       = rsp_flags_o[FLG_OVF] | rsp_flags_o[FLG_UNF] | rsp_flags_o[FLG_INF];

    // Completed-handshake and exception counters; clear beats increment
    always_ff @(posedge clk_i) begin
        if (RST || stat_clr_i) begin
            r_stat_ops <= '0;
            r_stat_exc <= '0;
        end else if (w_handshake) begin
            r_stat_ops <= r_stat_ops + 32'd1;
            if (w_exc) begin
                r_stat_exc <= r_stat_exc + 32'd1;
            end
        end
    end

    assign stat_ops_o = r_stat_ops;
    assign stat_exc_o = r_stat_exc;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl. A stand-in for FPU_32b drives random junk on
// fpu_result_i/fpu_flags_i every cycle except the one edge at which the
// answer is due (acceptance edge + LAT), so a capture on any other edge
// shows up as a wrong result.
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    localparam int LAT = 5;

    logic        clk_i = 1'b0;
    logic        RST;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_opa_i;
    logic [31:0] req_opb_i;
    logic        req_op_i;
    logic [1:0]  req_mode_i;
    logic [31:0] fpu_opa_o;
    logic [31:0] fpu_opb_o;
    logic        fpu_op_o;
    logic [1:0]  fpu_mode_o;
    logic [31:0] fpu_result_i;
    logic [4:0]  fpu_flags_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic [4:0]  rsp_flags_o;
    logic        busy_o;
`ifdef FPU_ISSUE_STATS_EN
    logic [31:0] stat_ops_o;
    logic [31:0] stat_exc_o;
    logic        stat_clr_i;
    int          exp_ops = 0;
    int          exp_exc = 0;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_cap = -1;
    logic [31:0] ans_res = '0;
    logic [4:0]  ans_flg = '0;

    fpu_issue_ctrl #(.FPU_LAT(LAT), .CNT_W(8)) dut (
        .clk_i        (clk_i),
        .RST          (RST),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_opa_i    (req_opa_i),
        .req_opb_i    (req_opb_i),
        .req_op_i     (req_op_i),
        .req_mode_i   (req_mode_i),
        .fpu_opa_o    (fpu_opa_o),
        .fpu_opb_o    (fpu_opb_o),
        .fpu_op_o     (fpu_op_o),
        .fpu_mode_o   (fpu_mode_o),
        .fpu_result_i (fpu_result_i),
        .fpu_flags_i  (fpu_flags_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_flags_o  (rsp_flags_o),
        .busy_o       (busy_o)
`ifdef FPU_ISSUE_STATS_EN
        ,
        .stat_ops_o   (stat_ops_o),
        .stat_exc_o   (stat_exc_o),
        .stat_clr_i   (stat_clr_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // FPU_32b stand-in: answer only on the due edge, junk otherwise
    always @(negedge clk_i) begin
        if (cyc + 1 == exp_cap) begin
            fpu_result_i = ans_res;
            fpu_flags_i  = ans_flg;
        end else begin
            fpu_result_i = $urandom;
            fpu_flags_i  = 5'($urandom);
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [1:0] mode, input logic [31:0] res, input logic [4:0] flg,
                          input int stall, input bit stall_req, input bit clr,
                          output int acc_edge, output int hs_edge);
        bit got;
        int n;
        got = 0;
        n = 0;
        acc_edge = -1;
        hs_edge = -1;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_opa_i = a;
        req_opb_i = b;
        req_op_i = op;
        req_mode_i = mode;
        rsp_ready_i = (stall == 0);
        while (!got && n < 40) begin
            if (n > 0) @(negedge clk_i);
            if (req_ready_o === 1'b1) begin
                got = 1;
                exp_cap = cyc + 1 + LAT;
                ans_res = res;
                ans_flg = flg;
            end
            n++;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL accept_timeout req_ready_o=%b required=1 within 40 cycles", req_ready_o);
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i); #1;
        acc_edge = cyc;
        req_valid_i = 1'b0;
        req_opa_i = $urandom;
        req_opb_i = $urandom;
        total++;
        if ({fpu_opa_o, fpu_opb_o, fpu_op_o, fpu_mode_o, req_ready_o, busy_o} !== {a, b, op, mode, 2'b01}) begin
            bad++;
            $display("FAIL issue_ports got=%h_%h_%b_%b rdy=%b busy=%b required=%h_%h_%b_%b rdy=0 busy=1",
                     fpu_opa_o, fpu_opb_o, fpu_op_o, fpu_mode_o, req_ready_o, busy_o, a, b, op, mode);
        end
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk_i); #1;
            if (k < LAT) begin
                total++;
                if ({rsp_valid_o, req_ready_o, fpu_opa_o, fpu_opb_o} !== {2'b00, a, b}) begin
                    bad++;
                    $display("FAIL wait_hold k=%0d got vld=%b rdy=%b opa=%h opb=%h required vld=0 rdy=0 opa=%h opb=%h",
                             k, rsp_valid_o, req_ready_o, fpu_opa_o, fpu_opb_o, a, b);
                end
            end
        end
        total++;
        if ({rsp_valid_o, rsp_result_o, rsp_flags_o} !== {1'b1, res, flg}) begin
            bad++;
            $display("FAIL capture got vld=%b res=%h flg=%b required vld=1 res=%h flg=%b",
                     rsp_valid_o, rsp_result_o, rsp_flags_o, res, flg);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk_i);
            if (stall_req) begin
                req_valid_i = 1'b1;
                req_opa_i = $urandom;
                req_opb_i = $urandom;
            end
            @(posedge clk_i); #1;
            total++;
            if ({rsp_valid_o, req_ready_o, rsp_result_o, rsp_flags_o, fpu_opa_o, fpu_opb_o} !== {2'b10, res, flg, a, b}) begin
                bad++;
                $display("FAIL stall s=%0d got vld=%b rdy=%b res=%h flg=%b opa=%h required vld=1 rdy=0 res=%h flg=%b opa=%h",
                         s, rsp_valid_o, req_ready_o, rsp_result_o, rsp_flags_o, fpu_opa_o, res, flg, a);
            end
        end
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
`ifdef FPU_ISSUE_STATS_EN
        stat_clr_i = clr;
`endif
        @(posedge clk_i); #1;
        hs_edge = cyc;
        total++;
        if ({rsp_valid_o, req_ready_o, busy_o, rsp_result_o, rsp_flags_o, fpu_opa_o} !== {3'b010, res, flg, a}) begin
            bad++;
            $display("FAIL handshake got vld=%b rdy=%b busy=%b res=%h flg=%b opa=%h required vld=0 rdy=1 busy=0 res=%h flg=%b opa=%h",
                     rsp_valid_o, req_ready_o, busy_o, rsp_result_o, rsp_flags_o, fpu_opa_o, res, flg, a);
        end
`ifdef FPU_ISSUE_STATS_EN
        stat_clr_i = 1'b0;
        if (clr) begin
            exp_ops = 0;
            exp_exc = 0;
        end else begin
            exp_ops++;
            if (flg[FLG_OVF] || flg[FLG_UNF] || flg[FLG_INF]) exp_exc++;
        end
        total++;
        if (stat_ops_o !== 32'(exp_ops) || stat_exc_o !== 32'(exp_exc)) begin
            bad++;
            $display("FAIL stats got ops=%0d exc=%0d required ops=%0d exc=%0d", stat_ops_o, stat_exc_o, exp_ops, exp_exc);
        end
`endif
    endtask

    task automatic check_idle_zero(input string name);
        total++;
        if ({fpu_opa_o, fpu_opb_o, fpu_op_o, fpu_mode_o, rsp_valid_o, rsp_result_o, rsp_flags_o, busy_o} !== '0
            || req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s got opa=%h opb=%h op=%b mode=%b vld=%b res=%h flg=%b busy=%b rdy=%b required all 0 rdy=1",
                     name, fpu_opa_o, fpu_opb_o, fpu_op_o, fpu_mode_o, rsp_valid_o, rsp_result_o, rsp_flags_o,
                     busy_o, req_ready_o);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(posedge clk_i); #1;
        check_idle_zero("reset_state");
        @(posedge clk_i); #1;
        @(negedge clk_i);
        RST = 1'b0;
    endtask

    task automatic test_basic();
        int e, h;
        run_op(32'h3F800000, 32'h3F800000, FPU_OP_ADD, RM_NEAREST, 32'h40000000, 5'b00000, 0, 0, 0, e, h);
        run_op(32'h41200000, 32'h41200000, FPU_OP_SUB, RM_ZERO, 32'h00000000, 5'b00001, 2, 0, 0, e, h);
        total++;
        if (rsp_flags_o[FLG_ZERO] !== 1'b1) begin
            bad++;
            $display("FAIL sub_zero_flag got=%b required=1", rsp_flags_o[FLG_ZERO]);
        end
    endtask

    task automatic test_backpressure();
        int e, h, e2, h2;
        run_op(32'h40200000, 32'h40200000, FPU_OP_ADD, RM_UP, 32'h40A00000, 5'b00000, 10, 1, 0, e, h);
        run_op(32'h3F800000, 32'h3F800000, FPU_OP_ADD, RM_DOWN, 32'h40000000, 5'b00000, 0, 0, 0, e2, h2);
        total++;
        if (e2 != h + 1) begin
            bad++;
            $display("FAIL accept_after_stall got edge=%0d required=%0d", e2, h + 1);
        end
    endtask

    task automatic test_back_to_back();
        int e[3];
        int h;
        run_op(32'h3F800000, 32'h3F800000, FPU_OP_ADD, RM_NEAREST, 32'h40000000, 5'b00000, 0, 0, 0, e[0], h);
        run_op(32'h3F800000, 32'h3F800000, FPU_OP_ADD, RM_NEAREST, 32'h40000000, 5'b00000, 0, 0, 0, e[1], h);
        run_op(32'h3FC00000, 32'h40000000, FPU_OP_ADD, RM_NEAREST, 32'h40600000, 5'b00000, 0, 0, 0, e[2], h);
        for (int i = 1; i < 3; i++) begin
            total++;
            if (e[i] - e[i-1] != LAT + 2) begin
                bad++;
                $display("FAIL b2b_spacing i=%0d got=%0d required=%0d", i, e[i] - e[i-1], LAT + 2);
            end
        end
    endtask

    task automatic test_random();
        int e, h;
        for (int i = 0; i < 10; i++) begin
            run_op($urandom, $urandom, 1'($urandom), 2'($urandom), $urandom, 5'($urandom),
                   int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 0, e, h);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        seen = 0;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_opa_i = 32'h3F800000;
        req_opb_i = 32'h40000000;
        req_op_i = FPU_OP_SUB;
        req_mode_i = RM_UP;
        exp_cap = cyc + 1 + LAT;
        ans_res = 32'hBF800000;
        ans_flg = 5'b00000;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        RST = 1'b1;
        @(posedge clk_i); #1;
        check_idle_zero("reset_mid_wait");
        @(negedge clk_i);
        RST = 1'b0;
        @(posedge clk_i); #1;
        check_idle_zero("after_reset_release");
        for (int k = 0; k < LAT + 3; k++) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abandoned_op got rsp_valid or busy raised required none");
        end
    endtask

`ifdef FPU_ISSUE_STATS_EN
    task automatic test_stats();
        int e, h;
        RST = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        RST = 1'b0;
        exp_ops = 0;
        exp_exc = 0;
        run_op(32'h3F800000, 32'h3F800000, FPU_OP_ADD, RM_NEAREST, 32'h40000000, 5'b00000, 0, 0, 0, e, h);
        run_op(32'h7F000000, 32'h7F000000, FPU_OP_ADD, RM_NEAREST, 32'h7F800000, 5'b11010, 1, 0, 0, e, h);
        run_op(32'h00800000, 32'h00800001, FPU_OP_SUB, RM_ZERO, 32'h80000001, 5'b10100, 0, 0, 0, e, h);
        run_op(32'h41200000, 32'h41200000, FPU_OP_SUB, RM_NEAREST, 32'h00000000, 5'b00001, 2, 0, 0, e, h);
        total++;
        if (stat_ops_o !== 32'd4 || stat_exc_o !== 32'd2) begin
            bad++;
            $display("FAIL stats_before_clr got ops=%0d exc=%0d required ops=4 exc=2", stat_ops_o, stat_exc_o);
        end
        run_op(32'h7F000000, 32'h7F000000, FPU_OP_ADD, RM_NEAREST, 32'h7F800000, 5'b11010, 0, 0, 1, e, h);
        total++;
        if (stat_ops_o !== 32'd0 || stat_exc_o !== 32'd0) begin
            bad++;
            $display("FAIL stats_after_clr got ops=%0d exc=%0d required 0", stat_ops_o, stat_exc_o);
        end
    endtask
`endif

    initial begin
        RST = 1'b1;
        req_valid_i = 1'b0;
        req_opa_i = '0;
        req_opb_i = '0;
        req_op_i = 1'b0;
        req_mode_i = '0;
        rsp_ready_i = 1'b0;
        fpu_result_i = '0;
        fpu_flags_i = '0;
`ifdef FPU_ISSUE_STATS_EN
        stat_clr_i = 1'b0;
`endif
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_wait();
`ifdef FPU_ISSUE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
